spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SIZE, default 40, frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on sclk_in, cs_n_in and mosi_in.
REQ-003 clk_in  input  1  system clock; all logic on its rising edge; one clock only.
REQ-004 reset_n_in  input  1  reset; asynchronous assert, active-low.
REQ-005 sclk_in  input  1  SPI clock from the master; asynchronous, idles high (mode 3).
REQ-006 cs_n_in  input  1  chip select from the master; asynchronous, active-low.
REQ-007 mosi_in  input  1  serial data from the master; asynchronous.
REQ-008 miso_out  output  1  serial data to the master.
REQ-009 miso_oe_out  output  1  MISO output enable; high only while selected.
REQ-010 tx_data_in  input  SIZE  word to transmit; captured at frame start.
REQ-011 data_out  output  SIZE  last complete received word.
REQ-012 r_valid_out  output  1  one-cycle pulse when data_out updates.
REQ-013 r_busy_out  output  1  high while a frame is in progress.
REQ-014 r_frame_err_out  output  1  one-cycle pulse on a frame aborted short.

Function
REQ-015 The block SHALL implement SPI mode 3 (CPOL=1, CPHA=1), MSB first: drive MISO on falling sclk edges and sample MOSI on rising sclk edges.
REQ-016 The block SHALL synchronize sclk_in, cs_n_in and mosi_in through SYNC_STAGES flops and detect edges from the synchronized values only.
REQ-017 The supported operating range SHALL be sclk high and low phases each at least SYNC_STAGES+2 clk_in periods.
REQ-018 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE.
REQ-019 IDLE -> SHIFT on a synchronized cs_n falling edge: load tx_data_in into the TX shift register, clear the bit counter, assert r_busy_out and miso_oe_out.
REQ-020 In SHIFT, each synchronized sclk falling edge SHALL present the next TX bit on miso_out, starting with tx_data_in[SIZE-1].
REQ-021 In SHIFT, each synchronized sclk rising edge SHALL shift mosi into the RX register LSB-ward and increment the bit counter.
REQ-022 On the rising edge that completes bit SIZE, the block SHALL copy the RX register to data_out, pulse r_valid_out for one cycle the following cycle, and enter DONE.
REQ-023 In DONE, further sclk edges SHALL be ignored; miso_out SHALL be held at 0; data_out SHALL be held.
REQ-024 A cs_n rising edge in DONE SHALL return the FSM to IDLE with no pulse.
REQ-025 A cs_n rising edge in SHIFT SHALL return the FSM to IDLE. If the bit count is in 1..SIZE-1, r_frame_err_out SHALL pulse for one cycle. data_out SHALL be left unchanged.
REQ-026 A cs_n rising edge in SHIFT with a bit count of 0 SHALL return the FSM to IDLE with no error pulse.
REQ-027 sclk edges while in IDLE SHALL be ignored.
REQ-028 If a cs_n edge and an sclk edge are detected in the same cycle, the cs_n edge SHALL take priority.
REQ-029 In IDLE, miso_oe_out=0, miso_out=1 and r_busy_out=0.
REQ-030 The bit counter SHALL be $clog2(SIZE)+1 bits wide and SHALL never wrap within a frame.
REQ-031 tx_data_in changes after frame start SHALL have no effect on the current frame.

Reset
REQ-032 Assertion of reset_n_in low SHALL asynchronously force: state IDLE, data_out=0, r_valid_out=0, r_busy_out=0, r_frame_err_out=0, miso_out=1, miso_oe_out=0, counter=0, and all synchronizer flops to idle levels (sclk=1, cs_n=1, mosi=0).
REQ-033 Reset asserted mid-frame SHALL discard the frame with no r_valid_out and no r_frame_err_out pulse.
REQ-034 After reset release, a frame SHALL start only on a fresh cs_n falling edge. A cs_n already low at release SHALL NOT start a frame.

Structure
REQ-035 The FSM state encodings (IDLE=0, SHIFT=1, DONE=2) and the SPI mode constant SHALL live in a shared package spi_pkg, reused by the master.
REQ-036 Input synchronization SHALL be a sub-module, sync_ff (parameter SYNC_STAGES, async active-low reset, parameterizable reset value), instantiated three times.

Verification
REQ-037 SIZE=40, tx_data_in=40'hA5_1234_5678, master sends 40'hC3_DEAD_BEEF at sclk=clk_in/8 -> one r_valid_out pulse with data_out=40'hC3DEADBEEF; master receives 40'hA512345678.
REQ-038 Master drops cs_n after 17 bits -> r_frame_err_out pulses once, no r_valid_out, data_out keeps its prior value.
REQ-039 Master sends 45 clocks in one frame -> data_out holds the first 40 bits, exactly one r_valid_out pulse, miso_out=0 for bits 41-45.
REQ-040 reset_n_in asserted after bit 20, then released with cs_n low -> all outputs at reset values, no frame until cs_n toggles high then low.
REQ-041 Back-to-back frames with a 4-clk_in cs_n high gap, tx_data_in changed during frame 1 -> frame 2 transmits the new value and two r_valid_out pulses occur.
REQ-042 sclk toggling while cs_n is high -> no state change, miso_oe_out stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the slave and the master.
// Holds FSM state encodings and the SPI mode constants.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

    // Mode 3: sclk idles high, data launched on fall, sampled on rise.
    localparam int   SPI_MODE = 3;
    localparam logic SPI_CPOL = 1'b1;
    localparam logic SPI_CPHA = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Ports: clk_in, reset_n_in (async, active-low), d (async in), q (synced out).
module sync_ff #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            ff <= {SYNC_STAGES{RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 slave, MSB first, oversampled on clk_in.
// Ports: sclk_in/cs_n_in/mosi_in (async SPI), miso_out/miso_oe_out,
// tx_data_in (captured at frame start), data_out + r_valid_out (rx word),
// r_busy_out (frame active), r_frame_err_out (short frame abort).
module spi_slave
    import spi_pkg::*;
#(
    parameter int SIZE        = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic            sclk_in,
    input  logic            cs_n_in,
    input  logic            mosi_in,
    output logic            miso_out,
    output logic            miso_oe_out,
    input  logic [SIZE-1:0] tx_data_in,
    output logic [SIZE-1:0] data_out,
    output logic            r_valid_out,
    output logic            r_busy_out,
    output logic            r_frame_err_out
);

    localparam int CW = $clog2(SIZE) + 1;
    localparam int FW = $clog2(SYNC_STAGES + 1) + 1;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_q, cs_q;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [FW-1:0] flush_cnt;
    logic          flush_done;
    logic          armed;

    spi_state_e    state, state_nx;
    logic [SIZE-1:0] tx_sr, rx_sr;
    logic [CW-1:0]   bit_cnt;
    logic            last_bit;

    logic load, tx_step, rx_step, capture, to_idle, short_abort;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .d(sclk_in), .q(sclk_s)
    );

    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .d(cs_n_in), .q(cs_s)
    );

    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .d(mosi_in), .q(mosi_s)
    );

    // The synchronizer output is only trustworthy once its reset value has
    // been flushed; a frame may start only after cs_n has then been seen
    // high, so a cs_n already low at reset release never opens a frame.
    assign flush_done = (flush_cnt == FW'(SYNC_STAGES));

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sclk_q    <= 1'b1;
            cs_q      <= 1'b1;
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
            if (!flush_done) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (flush_done && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign cs_fall   = armed & cs_q & ~cs_s;
    assign last_bit  = (bit_cnt == CW'(SIZE - 1));

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // cs_n edges are tested before sclk edges so they win on a tie.
    always_comb begin
        state_nx    = state;
        load        = 1'b0;
        tx_step     = 1'b0;
        rx_step     = 1'b0;
        capture     = 1'b0;
        to_idle     = 1'b0;
        short_abort = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nx = SHIFT;
                    load     = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nx    = IDLE;
                    to_idle     = 1'b1;
                    short_abort = (bit_cnt != '0);
                end else begin
                    tx_step = sclk_fall;
                    if (sclk_rise) begin
                        rx_step = 1'b1;
                        if (last_bit) begin
                            capture  = 1'b1;
                            state_nx = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_nx = IDLE;
                    to_idle  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                to_idle  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            tx_sr           <= '0;
            rx_sr           <= '0;
            bit_cnt         <= '0;
            data_out        <= '0;
            r_valid_out     <= 1'b0;
            r_frame_err_out <= 1'b0;
            r_busy_out      <= 1'b0;
            miso_out        <= 1'b1;
            miso_oe_out     <= 1'b0;
        end else begin
            r_valid_out     <= capture;
            r_frame_err_out <= short_abort;
            if (load) begin
                tx_sr       <= tx_data_in;
                rx_sr       <= '0;
                bit_cnt     <= '0;
                r_busy_out  <= 1'b1;
                miso_oe_out <= 1'b1;
            end
            if (tx_step) begin
                miso_out <= tx_sr[SIZE-1];
                tx_sr    <= {tx_sr[SIZE-2:0], 1'b0};
            end
            if (rx_step) begin
                rx_sr   <= {rx_sr[SIZE-2:0], mosi_s};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (capture) begin
                data_out <= {rx_sr[SIZE-2:0], mosi_s};
                miso_out <= 1'b0;
            end
            if (to_idle) begin
                r_busy_out  <= 1'b0;
                miso_oe_out <= 1'b0;
                miso_out    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: table of frames plus hand sequences
// for reset mid-frame, back-to-back frames and idle sclk activity.
module tb_spi_slave;

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic        sclk_in = 1'b1;
    logic        cs_n_in = 1'b1;
    logic        mosi_in = 1'b0;
    logic        miso_out;
    logic        miso_oe_out;
    logic [39:0] tx_data_in = '0;
    logic [39:0] data_out;
    logic        r_valid_out;
    logic        r_busy_out;
    logic        r_frame_err_out;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_err = 0;

    spi_slave #(.SIZE(40), .SYNC_STAGES(2)) dut (
        .clk_in         (clk_in),
        .reset_n_in     (reset_n_in),
        .sclk_in        (sclk_in),
        .cs_n_in        (cs_n_in),
        .mosi_in        (mosi_in),
        .miso_out       (miso_out),
        .miso_oe_out    (miso_oe_out),
        .tx_data_in     (tx_data_in),
        .data_out       (data_out),
        .r_valid_out    (r_valid_out),
        .r_busy_out     (r_busy_out),
        .r_frame_err_out(r_frame_err_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (r_valid_out) n_valid++;
        if (r_frame_err_out) n_err++;
    end

    typedef struct {
        logic [63:0] mosi;
        logic [39:0] tx;
        int          nbits;
        int          exp_valid;
        int          exp_err;
        logic [39:0] exp_data;
        logic [63:0] exp_miso;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic cs_low();
        cs_n_in = 1'b0;
        wclk(4);
    endtask

    task automatic cs_high(input int gap);
        cs_n_in = 1'b1;
        wclk(gap);
    endtask

    // Master side: drive mosi on sclk fall, sample miso just before rise.
    task automatic send_bits(input logic [63:0] w, input int n,
                             output logic [63:0] r);
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sclk_in = 1'b0;
            mosi_in = w[i];
            wclk(4);
            r = {r[62:0], miso_out};
            sclk_in = 1'b1;
            wclk(4);
        end
    endtask

    logic [63:0] rx;
    logic [63:0] rx2;

    initial begin
        vecs[0] = '{{24'd0, 40'hC3DEADBEEF}, 40'hA512345678, 40, 1, 0,
                    40'hC3DEADBEEF, {24'd0, 40'hA512345678}};
        vecs[1] = '{64'h1ABCD, 40'hA512345678, 17, 0, 1,
                    40'hC3DEADBEEF, 64'h14A24};
        vecs[2] = '{{19'd0, 40'h0123456789, 5'b10101}, 40'hFFFFFFFFFF, 45,
                    1, 0, 40'h0123456789, {19'd0, 40'hFFFFFFFFFF, 5'b00000}};
        vecs[3] = '{64'h0, 40'h123, 0, 0, 0, 40'h0123456789, 64'h0};
        vecs[4] = '{64'h1, 40'h8000000000, 1, 0, 1, 40'h0123456789, 64'h1};
        vecs[5] = '{64'h7FFFFFFFFF, 40'h0000000003, 39, 0, 1,
                    40'h0123456789, 64'h1};
        vecs[6] = '{64'h1, 40'hFFFF0000FF, 40, 1, 0, 40'h0000000001,
                    {24'd0, 40'hFFFF0000FF}};

        wclk(3);
        chk("rst_data", 64'(data_out), 64'h0);
        chk("rst_miso", 64'(miso_out), 64'h1);
        chk("rst_oe", 64'(miso_oe_out), 64'h0);
        chk("rst_busy", 64'(r_busy_out), 64'h0);
        chk("rst_valid", 64'(r_valid_out), 64'h0);
        chk("rst_err", 64'(r_frame_err_out), 64'h0);
        reset_n_in = 1'b1;
        wclk(8);

        for (int v = 0; v < 7; v++) begin
            n_valid = 0;
            n_err = 0;
            tx_data_in = vecs[v].tx;
            cs_low();
            send_bits(vecs[v].mosi, vecs[v].nbits, rx);
            cs_high(10);
            chk($sformatf("v%0d_valid", v), 64'(n_valid), 64'(vecs[v].exp_valid));
            chk($sformatf("v%0d_err", v), 64'(n_err), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d_data", v), 64'(data_out), 64'(vecs[v].exp_data));
            chk($sformatf("v%0d_miso_word", v), rx, vecs[v].exp_miso);
            chk($sformatf("v%0d_idle_busy", v), 64'(r_busy_out), 64'h0);
            chk($sformatf("v%0d_idle_oe", v), 64'(miso_oe_out), 64'h0);
            chk($sformatf("v%0d_idle_miso", v), 64'(miso_out), 64'h1);
        end

        // Reset after bit 20 with cs_n held low through release.
        n_valid = 0;
        n_err = 0;
        tx_data_in = 40'h1122334455;
        cs_low();
        send_bits(64'hFFFFF, 20, rx);
        chk("mid_busy", 64'(r_busy_out), 64'h1);
        chk("mid_oe", 64'(miso_oe_out), 64'h1);
        reset_n_in = 1'b0;
        #1;
        chk("arst_data", 64'(data_out), 64'h0);
        chk("arst_busy", 64'(r_busy_out), 64'h0);
        chk("arst_oe", 64'(miso_oe_out), 64'h0);
        chk("arst_miso", 64'(miso_out), 64'h1);
        wclk(3);
        reset_n_in = 1'b1;
        wclk(10);
        send_bits(64'h3FF, 10, rx);
        wclk(4);
        chk("rel_busy", 64'(r_busy_out), 64'h0);
        chk("rel_oe", 64'(miso_oe_out), 64'h0);
        chk("rel_pulses", 64'(n_valid + n_err), 64'h0);
        chk("rel_data", 64'(data_out), 64'h0);
        cs_high(8);
        cs_low();
        send_bits({24'd0, 40'h5555AAAA33}, 40, rx);
        cs_high(10);
        chk("rel_frame_valid", 64'(n_valid), 64'h1);
        chk("rel_frame_data", 64'(data_out), 64'h5555AAAA33);
        chk("rel_frame_miso", rx, {24'd0, 40'h1122334455});

        // Back-to-back frames; tx_data_in changes mid frame 1.
        n_valid = 0;
        n_err = 0;
        tx_data_in = 40'hA512345678;
        cs_low();
        send_bits(64'hABCDE, 20, rx);
        tx_data_in = 40'h5A5A5A5A5A;
        send_bits(64'h12345, 20, rx2);
        rx = {rx[43:0], rx2[19:0]};
        cs_high(4);
        cs_low();
        send_bits({24'd0, 40'h0F1E2D3C4B}, 40, rx2);
        cs_high(10);
        chk("b2b_f1_miso", rx, {24'd0, 40'hA512345678});
        chk("b2b_f2_miso", rx2, {24'd0, 40'h5A5A5A5A5A});
        chk("b2b_valid", 64'(n_valid), 64'h2);
        chk("b2b_err", 64'(n_err), 64'h0);
        chk("b2b_data", 64'(data_out), 64'h0F1E2D3C4B);

        // sclk activity with cs_n high must leave the slave untouched.
        n_valid = 0;
        n_err = 0;
        begin
            int oe_seen;
            oe_seen = 0;
            for (int i = 0; i < 10; i++) begin
                sclk_in = 1'b0;
                mosi_in = i[0];
                wclk(4);
                if (miso_oe_out || r_busy_out) oe_seen++;
                sclk_in = 1'b1;
                wclk(4);
                if (miso_oe_out || r_busy_out) oe_seen++;
            end
            chk("idle_sclk_oe", 64'(oe_seen), 64'h0);
        end
        chk("idle_sclk_pulses", 64'(n_valid + n_err), 64'h0);
        chk("idle_sclk_data", 64'(data_out), 64'h0F1E2D3C4B);
        chk("idle_sclk_miso", 64'(miso_out), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
